scandoubler_mode_ctrl: RTL and testbench
========================================

// Module: scandoubler_mode_ctrl
//
// PURPOSE
// Sequencer and configurator for the VGA scandoubler. Measures the incoming 15 kHz
// line length (clk14en ticks) and the number of lines per frame from the external
// syncs, and declares lock once the line length is stable and fits one scan-buffer
// half (1024 entries). Drives the scandoubler's enable_scandoubling and
// disable_scaneffect inputs. Mode changes are applied only at a frame boundary, so
// the monitor never sees a torn frame.
//
// PARAMETERS
// LOCK_LINES  16    consecutive matching lines after the reference line needed to lock
// TOL         2     max |meas - line_len| in ticks that still counts as a match
// MIN_LINE    256   shortest valid line, in ticks
// HTIMEOUT    2047  ticks with no hsync fall before forcing SEARCH (<= 2047)
//
// PORTS
// clk                  in   1   system clock (same clock as the scandoubler)
// rst_n                in   1   reset: asynchronous, active low
// clk14en              in   1   pixel-rate enable; all sync sampling and counting happen on ticks only
// hsync_ext_n          in   1   source horizontal sync, active low
// vsync_ext_n          in   1   source vertical sync, active low
// cfg_scandbl          in   1   user request: 1 = VGA (31 kHz) output
// cfg_scanlines        in   1   user request: 1 = scanline effect on
// enable_scandoubling  out  1   to scandoubler; 1 only while locked and requested
// disable_scaneffect   out  1   to scandoubler; registered ~cfg_scanlines
// locked               out  1   line-length lock indicator
// line_len             out  10  accepted reference line length in ticks
// frame_lines          out  10  hsync falls counted in the last complete frame
// mode_changed         out  1   one-clk pulse whenever enable_scandoubling toggles
//
// BEHAVIOUR
// - Reset (async, rst_n=0): state=SEARCH; enable_scandoubling=0, disable_scaneffect=1,
//   locked=0, line_len=0, frame_lines=0, mode_changed=0, all counters 0, sync history 1.
// - Edge detect: hsync/vsync history registers update only on clk14en. A fall is
//   prev=1 and cur=0 on a tick.
// - hcnt (11 b): increments on each tick and saturates at 2047. On an hsync-fall tick:
//   meas = hcnt+1, hcnt <= 0. Consecutive falls N ticks apart therefore give meas = N.
// - A meas is valid when MIN_LINE <= meas <= 1023. A valid meas matches when
//   |meas - line_len| <= TOL.
// - FSM:
//   SEARCH:  locked=0. The first fall only arms the measurement. The next fall with a
//            valid meas sets line_len <= meas, good <= 0, and moves to MEASURE.
//   MEASURE: on each fall: a match increments good, and reaching LOCK_LINES goes to
//            LOCKED. A valid mismatch sets line_len <= meas, good <= 0. An invalid
//            meas goes to SEARCH (disarmed).
//   LOCKED:  locked=1. line_len holds its value (no tracking). A valid mismatch goes
//            to MEASURE with line_len <= meas and good <= 0. An invalid meas goes to
//            SEARCH.
//   Any state: hcnt reaching HTIMEOUT goes to SEARCH (disarmed). locked is a
//   registered decode of the state.
// - vcnt (10 b, saturates at 1023): +1 per hsync fall. On a vsync-fall tick:
//   frame_lines <= vcnt (plus 1 if an hsync fall occurs on the same tick), vcnt <= 0.
// - Mode apply: target = cfg_scandbl & locked.
//   - On a vsync-fall tick: enable_scandoubling <= target and
//     disable_scaneffect <= ~cfg_scanlines.
//   - Exception: when locked falls, enable_scandoubling <= 0 on the next clk,
//     without waiting for vsync.
//   - mode_changed = 1 for exactly one clk after any change of enable_scandoubling.
// - cfg_* are treated as quasi-static; each is sampled only at the apply point.
// - Without clk14en, nothing changes except the forced drop of enable_scandoubling.
//
// TESTING
// 1. Lock and switch: hsync period 896 ticks, 312 lines/frame, cfg_scandbl=1.
//    -> locked rises at the 18th hsync fall, line_len=896; enable_scandoubling rises
//    at the next vsync fall, mode_changed high 1 clk; frame_lines=312.
// 2. Tolerance: once locked, periods 898 then 894. -> locked stays 1. Then a period
//    of 899 -> locked=0 next clk, enable_scandoubling=0 next clk, line_len=899,
//    relock after 16 matches.
// 3. Buffer limit: period 1100 ticks, and separately 200 ticks. -> locked never
//    rises, enable_scandoubling stays 0.
// 4. Timeout and frame edge: stop hsync while locked. -> SEARCH 2047 ticks after the
//    last fall, locked=0. An hsync fall on the same tick as a vsync fall is counted
//    in the ending frame.
// 5. Deferred config: toggle cfg_scanlines mid-frame. -> disable_scaneffect changes
//    only at the next vsync fall. Set cfg_scandbl=0 while locked -> output drops at
//    the next vsync fall.
// 6. Async reset: rst_n low mid-LOCKED, asserted between clk edges. -> all outputs
//    at reset values immediately; the relock sequence restarts from SEARCH.

Source files
------------

// File: rtl/scandoubler_mode_ctrl.sv
// Scandoubler sequencer: measures source line length and lines per frame, locks onto a
// stable line that fits one scan-buffer half, and applies output mode at frame boundaries.
//
// state   | meaning
// --------+------------------------------------------------------------------
// SEARCH  | no reference; first hsync fall arms, next valid fall sets line_len
// MEASURE | reference held; counting consecutive matching lines toward lock
// LOCKED  | line length stable; scandoubling may be enabled at next vsync fall
module scandoubler_mode_ctrl #(
  parameter int unsigned LOCK_LINES = 16,
  parameter int unsigned TOL        = 2,
  parameter int unsigned MIN_LINE   = 256,
  parameter int unsigned HTIMEOUT   = 2047
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk14en,
  input  logic       hsync_ext_n,
  input  logic       vsync_ext_n,
  input  logic       cfg_scandbl,
  input  logic       cfg_scanlines,
  output logic       enable_scandoubling,
  output logic       disable_scaneffect,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       mode_changed
);

  localparam int unsigned GW = $clog2(LOCK_LINES + 1);
  localparam logic [GW-1:0] LOCK_W     = GW'(LOCK_LINES);
  localparam logic [11:0]   TOL_W      = 12'(TOL);
  localparam logic [11:0]   MIN_W      = 12'(MIN_LINE);
  localparam logic [11:0]   MAX_W      = 12'd1023;
  localparam logic [10:0]   HTIMEOUT_W = 11'(HTIMEOUT);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          armed_q, armed_d;
  logic [GW-1:0] good_q, good_d;
  logic [10:0]   hcnt_q, hcnt_d;
  logic [9:0]    vcnt_q, vcnt_d;
  logic          hs_q, vs_q;
  logic [9:0]    line_len_q, line_len_d;
  logic [9:0]    frame_lines_q, frame_lines_d;
  logic          locked_q, locked_d;
  logic          en_q, en_d;
  logic          dis_q, dis_d;
  logic          mc_q, mc_d;

  logic          hs_fall, vs_fall;
  logic [11:0]   meas, ll_ext, diff;
  logic          meas_valid, meas_match;
  logic [10:0]   hcnt_inc;
  logic [9:0]    vcnt_hs;
  logic [GW-1:0] good_inc;
  logic          timeout;

  // Falls are judged against the history sampled on the previous tick only.
  assign hs_fall = clk14en & hs_q & ~hsync_ext_n;
  assign vs_fall = clk14en & vs_q & ~vsync_ext_n;

  assign meas       = {1'b0, hcnt_q} + 12'd1;
  assign ll_ext     = {2'b00, line_len_q};
  assign diff       = (meas >= ll_ext) ? (meas - ll_ext) : (ll_ext - meas);
  assign meas_valid = (meas >= MIN_W) && (meas <= MAX_W);
  assign meas_match = meas_valid && (diff <= TOL_W);
  assign hcnt_inc   = (hcnt_q == 11'h7FF) ? hcnt_q : (hcnt_q + 11'd1);
  assign good_inc   = good_q + 1'b1;
  assign timeout    = clk14en & ~hs_fall & (hcnt_inc == HTIMEOUT_W);
  assign vcnt_hs    = (hs_fall && vcnt_q != 10'h3FF) ? (vcnt_q + 10'd1) : vcnt_q;

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    good_d     = good_q;
    line_len_d = line_len_q;
    if (timeout) begin
      state_d = ST_SEARCH;
      armed_d = 1'b0;
      good_d  = '0;
    end else if (hs_fall) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (!armed_q) begin
            armed_d = 1'b1;
          end else if (meas_valid) begin
            line_len_d = meas[9:0];
            good_d     = '0;
            state_d    = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (!meas_valid) begin
            state_d = ST_SEARCH;
            armed_d = 1'b0;
            good_d  = '0;
          end else if (meas_match) begin
            good_d = good_inc;
            if (good_inc == LOCK_W) state_d = ST_LOCKED;
          end else begin
            line_len_d = meas[9:0];
            good_d     = '0;
          end
        end
        ST_LOCKED: begin
          if (!meas_valid) begin
            state_d = ST_SEARCH;
            armed_d = 1'b0;
            good_d  = '0;
          end else if (!meas_match) begin
            state_d    = ST_MEASURE;
            line_len_d = meas[9:0];
            good_d     = '0;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          armed_d = 1'b0;
          good_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    frame_lines_d = frame_lines_q;
    if (clk14en) begin
      hcnt_d = hs_fall ? 11'd0 : hcnt_inc;
      if (vs_fall) begin
        frame_lines_d = vcnt_hs;
        vcnt_d        = 10'd0;
      end else begin
        vcnt_d = vcnt_hs;
      end
    end
  end

  // Mode is applied only at vsync; losing lock is the one case that cannot wait.
  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    en_d     = en_q;
    dis_d    = dis_q;
    if (vs_fall) begin
      en_d  = cfg_scandbl & locked_q;
      dis_d = ~cfg_scanlines;
    end
    if (!locked_d) en_d = 1'b0;
    mc_d = en_d ^ en_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SEARCH;
      armed_q       <= 1'b0;
      good_q        <= '0;
      hcnt_q        <= 11'd0;
      vcnt_q        <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_len_q    <= 10'd0;
      frame_lines_q <= 10'd0;
      locked_q      <= 1'b0;
      en_q          <= 1'b0;
      dis_q         <= 1'b1;
      mc_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      good_q        <= good_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      if (clk14en) begin
        hs_q <= hsync_ext_n;
        vs_q <= vsync_ext_n;
      end
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      locked_q      <= locked_d;
      en_q          <= en_d;
      dis_q         <= dis_d;
      mc_q          <= mc_d;
    end
  end

  assign enable_scandoubling = en_q;
  assign disable_scaneffect  = dis_q;
  assign locked              = locked_q;
  assign line_len            = line_len_q;
  assign frame_lines         = frame_lines_q;
  assign mode_changed        = mc_q;

endmodule

// File: tb/tb_scandoubler_mode_ctrl.sv
// Bench for scandoubler_mode_ctrl: sync waveforms are built line by line and checked
// against a line-level lock/frame/mode model; clk14en has random idle gaps.
module tb_scandoubler_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, clk14en, hsync_ext_n, vsync_ext_n, cfg_scandbl, cfg_scanlines;
  logic       en, dis, locked, mc;
  logic [9:0] line_len, frame_lines;

  int checks = 0;
  int errors = 0;

  // reference model (line-level view of the sync stream)
  bit m_hprev, m_vprev, m_armed, m_have_ref, m_lock, m_en, m_dis, m_mc, m_evt_prev;
  int m_since, m_ref, m_run, m_vcnt, m_frame;

  scandoubler_mode_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .clk14en             (clk14en),
    .hsync_ext_n         (hsync_ext_n),
    .vsync_ext_n         (vsync_ext_n),
    .cfg_scandbl         (cfg_scandbl),
    .cfg_scanlines       (cfg_scanlines),
    .enable_scandoubling (en),
    .disable_scaneffect  (dis),
    .locked              (locked),
    .line_len            (line_len),
    .frame_lines         (frame_lines),
    .mode_changed        (mc)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_hprev = 1; m_vprev = 1; m_armed = 0; m_have_ref = 0; m_lock = 0;
    m_en = 0; m_dis = 1; m_mc = 0; m_evt_prev = 0;
    m_since = 0; m_ref = 0; m_run = 0; m_vcnt = 0; m_frame = 0;
  endtask

  task automatic model_line(input int meas);
    bit valid;
    int d;
    valid = (meas >= 256) && (meas <= 1023);
    d = (meas > m_ref) ? meas - m_ref : m_ref - meas;
    if (!m_have_ref) begin
      if (!m_armed) m_armed = 1;
      else if (valid) begin m_ref = meas; m_run = 0; m_have_ref = 1; end
    end else if (!valid) begin
      m_have_ref = 0; m_armed = 0; m_lock = 0;
    end else if (d <= 2) begin
      if (!m_lock) begin
        m_run++;
        if (m_run >= 16) m_lock = 1;
      end
    end else begin
      m_ref = meas; m_run = 0; m_lock = 0;
    end
  endtask

  task automatic tick(input bit hs, input bit vs);
    bit hf, vf, lock_before, en_before;
    logic [23:0] act, exp;
    if ($urandom_range(0, 15) == 0) begin
      clk14en = 1'b0;
      @(posedge clk); #1;
    end
    hsync_ext_n = hs; vsync_ext_n = vs; clk14en = 1'b1;
    hf = m_hprev && !hs;
    vf = m_vprev && !vs;
    m_hprev = hs; m_vprev = vs;
    lock_before = m_lock; en_before = m_en;
    m_since++;
    if (hf) begin
      model_line((m_since > 2048) ? 2048 : m_since);
      m_since = 0;
      m_vcnt = (m_vcnt < 1023) ? m_vcnt + 1 : 1023;
    end else if (m_since >= 2047) begin
      m_have_ref = 0; m_armed = 0; m_lock = 0;
    end
    if (vf) begin
      m_frame = m_vcnt; m_vcnt = 0;
      m_en = cfg_scandbl && lock_before;
      m_dis = !cfg_scanlines;
    end
    if (!m_lock) m_en = 0;
    m_mc = (m_en != en_before);
    @(posedge clk); #1;
    clk14en = 1'b0;
    if (hf || vf || m_evt_prev || m_since == 2047) begin
      act = {locked, line_len, frame_lines, en, dis, mc};
      exp = {m_lock, m_ref[9:0], m_frame[9:0], m_en, m_dis, m_mc};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL tick_out t=%0t lock %b/%b len %0d/%0d frame %0d/%0d en %b/%b dis %b/%b mc %b/%b (got/want)",
                 $time, locked, m_lock, line_len, m_ref, frame_lines, m_frame, en, m_en, dis, m_dis, mc, m_mc);
      end
    end
    m_evt_prev = hf || vf;
  endtask

  task automatic send_line(input int period, input int vs_off);
    for (int t = 0; t < period; t++) begin
      bit hs, vs;
      hs = (t < 4) ? 1'b0 : 1'b1;
      vs = (vs_off >= 0 && t >= vs_off && t < vs_off + 3) ? 1'b0 : 1'b1;
      tick(hs, vs);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b want 0", locked); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", en); end
    checks++; if (dis !== 1'b1) begin errors++; $display("FAIL rst_dis got %b want 1", dis); end
    checks++; if (line_len !== 10'd0) begin errors++; $display("FAIL rst_line_len got %0d want 0", line_len); end
    checks++; if (frame_lines !== 10'd0) begin errors++; $display("FAIL rst_frame_lines got %0d want 0", frame_lines); end
    checks++; if (mc !== 1'b0) begin errors++; $display("FAIL rst_mc got %b want 0", mc); end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({locked, en, dis, mc} !== 4'b0010) begin
      errors++; $display("FAIL post_rst_idle got %b want 0010", {locked, en, dis, mc});
    end
  endtask

  task automatic test_lock_switch();
    int first_lock = 0;
    cfg_scandbl = 1'b1;
    cfg_scanlines = 1'($urandom_range(0, 1));
    for (int i = 1; i <= 20; i++) begin
      send_line(896, (i == 20) ? 200 : -1);
      if (locked === 1'b1 && first_lock == 0) first_lock = i;
    end
    checks++; if (first_lock != 18) begin errors++; $display("FAIL first_lock_fall got %0d want 18", first_lock); end
    checks++; if (line_len !== 10'd896) begin errors++; $display("FAIL lock_line_len got %0d want 896", line_len); end
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL lock_en got %b want 1", en); end
    checks++; if (frame_lines !== 10'd20) begin errors++; $display("FAIL lock_frame_lines got %0d want 20", frame_lines); end
    checks++; if (dis !== !cfg_scanlines) begin errors++; $display("FAIL lock_dis got %b want %b", dis, !cfg_scanlines); end
  endtask

  task automatic test_tolerance();
    send_line(898, -1);
    send_line(894, -1);
    send_line(899, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL tol_hold got %b want 1", locked); end
    send_line(899, -1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL tol_break_lock got %b want 0", locked); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL tol_break_en got %b want 0", en); end
    checks++; if (line_len !== 10'd899) begin errors++; $display("FAIL tol_break_len got %0d want 899", line_len); end
    for (int k = 3; k <= 17; k++) send_line(899, -1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early got %b want 0", locked); end
    send_line(899, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", locked); end
    send_line(899, 100);
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL relock_en got %b want 1", en); end
    checks++; if (frame_lines !== 10'd21) begin errors++; $display("FAIL tol_frame_lines got %0d want 21", frame_lines); end
  endtask

  task automatic test_deferred_cfg();
    logic old_dis;
    old_dis = dis;
    cfg_scanlines = ~cfg_scanlines;
    send_line(899, -1);
    checks++; if (dis !== old_dis) begin errors++; $display("FAIL dis_midframe got %b want %b", dis, old_dis); end
    send_line(899, 60);
    checks++; if (dis !== !cfg_scanlines) begin errors++; $display("FAIL dis_at_vsync got %b want %b", dis, !cfg_scanlines); end
    cfg_scandbl = 1'b0;
    send_line(899, -1);
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL en_midframe got %b want 1", en); end
    send_line(899, 60);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL en_off_at_vsync got %b want 0", en); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL cfg_off_locked got %b want 1", locked); end
    cfg_scandbl = 1'b1;
  endtask

  task automatic test_timeout_frame_edge();
    int n = 0;
    send_line(899, 50);
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL pre_timeout_en got %b want 1", en); end
    while (m_since < 2047 && n < 3000) begin
      tick(1'b1, 1'b1);
      n++;
      if (m_since == 2046) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL timeout_early got %b want 1", locked); end
      end
    end
    checks++; if (m_since != 2047) begin errors++; $display("FAIL timeout_bound ticks %0d want 2047 reached", m_since); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL timeout_locked got %b want 0", locked); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL timeout_en got %b want 0", en); end
    for (int i = 0; i < 3; i++) send_line(300, -1);
    send_line(300, 0);
    checks++; if (frame_lines !== 10'd4) begin errors++; $display("FAIL frame_edge_lines got %0d want 4", frame_lines); end
  endtask

  task automatic test_buffer_limit();
    cfg_scandbl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_line(1100, (i == 3) ? 100 : -1);
      checks++; if ({locked, en} !== 2'b00) begin errors++; $display("FAIL long_line lock/en got %b want 00", {locked, en}); end
    end
    for (int i = 0; i < 8; i++) begin
      send_line(200, (i == 7) ? 20 : -1);
      checks++; if ({locked, en} !== 2'b00) begin errors++; $display("FAIL short_line lock/en got %b want 00", {locked, en}); end
    end
    send_line(1023, -1);
    send_line(1023, -1);
    checks++; if (line_len !== 10'd1023) begin errors++; $display("FAIL max_valid_len got %0d want 1023", line_len); end
    send_line(1024, -1);
    send_line(300, -1);
    checks++; if ({locked, line_len} !== {1'b0, 10'd1023}) begin
      errors++; $display("FAIL over_max got lock %b len %0d want 0 1023", locked, line_len);
    end
  endtask

  task automatic test_random();
    int base, p, r, vo;
    base = $urandom_range(262, 330);
    for (int i = 0; i < 50; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) p = base + $urandom_range(0, 4) - 2;
      else if (r < 85) p = ($urandom_range(0, 1) != 0) ? base + $urandom_range(3, 8) : base - $urandom_range(3, 8);
      else if (r < 93) p = ($urandom_range(0, 1) != 0) ? 255 : 256;
      else p = $urandom_range(200, 250);
      vo = -1;
      if ($urandom_range(0, 5) == 0) begin
        cfg_scandbl = 1'($urandom_range(0, 1));
        cfg_scanlines = 1'($urandom_range(0, 1));
        vo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 150);
      end
      send_line(p, vo);
    end
  endtask

  task automatic test_async_reset();
    cfg_scandbl = 1'b1;
    for (int i = 0; i < 20; i++) send_line(260, -1);
    send_line(260, 30);
    checks++; if ({locked, en} !== 2'b11) begin errors++; $display("FAIL pre_reset lock/en got %b want 11", {locked, en}); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL async_locked got %b want 0", locked); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL async_en got %b want 0", en); end
    checks++; if (dis !== 1'b1) begin errors++; $display("FAIL async_dis got %b want 1", dis); end
    checks++; if (line_len !== 10'd0) begin errors++; $display("FAIL async_line_len got %0d want 0", line_len); end
    checks++; if (frame_lines !== 10'd0) begin errors++; $display("FAIL async_frame got %0d want 0", frame_lines); end
    checks++; if (mc !== 1'b0) begin errors++; $display("FAIL async_mc got %b want 0", mc); end
    hsync_ext_n = 1'b1; vsync_ext_n = 1'b1; clk14en = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 17; i++) send_line(260, -1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_relock_early got %b want 0", locked); end
    send_line(260, -1);
    checks++; if ({locked, line_len} !== {1'b1, 10'd260}) begin
      errors++; $display("FAIL reset_relock got lock %b len %0d want 1 260", locked, line_len);
    end
  endtask

  initial begin
    rst_n = 1'b0; clk14en = 1'b0; hsync_ext_n = 1'b1; vsync_ext_n = 1'b1;
    cfg_scandbl = 1'b0; cfg_scanlines = 1'b0;
    model_reset();
    test_reset();
    test_lock_switch();
    test_tolerance();
    test_deferred_cfg();
    test_timeout_frame_edge();
    test_buffer_limit();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
